// File: rtl/mpu_store.sv
// Drains one matrix register into a row-major valid/ready element stream, with ack/error completion pulses.
// Optional MPU_STORE_CHECKSUM_EN adds a running XOR checksum of every accepted element.
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [MATRIX_REG_SIZE-1:0]        store_addr,
  output logic [MATRIX_REG_SIZE-1:0]        reg_store_addr,
  input  logic [M-1:0][N-1:0][FP-1:0]       reg_matrix_in,
  input  logic [MBITS:0]                    reg_m_in,
  input  logic [NBITS:0]                    reg_n_in,
  output logic [FP-1:0]                     element,
  output logic                              element_valid,
  input  logic                              element_ready,
  output logic [MBITS:0]                    matrix_m_size,
  output logic [NBITS:0]                    matrix_n_size,
  output logic                              busy,
  output logic                              ack,
  output logic                              error
`ifdef MPU_STORE_CHECKSUM_EN
  ,
  output logic [FP-1:0]                     checksum
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, STREAM, DONE, ERR} state_t;

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
  localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

  state_t                        state_q, state_d;
  logic [M-1:0][N-1:0][FP-1:0]   snap_q;
  logic [MBITS-1:0]              row_q, row_nx;
  logic [NBITS-1:0]              col_q, col_nx;
  logic                          hs, last_col, last, bad_dims;

  assign hs       = element_valid && element_ready;
  assign last_col = {1'b0, col_q} == (matrix_n_size - N_ONE);
  assign last     = last_col && ({1'b0, row_q} == (matrix_m_size - M_ONE));
  assign bad_dims = (reg_m_in == '0) || (reg_n_in == '0) ||
                    (reg_m_in > M_MAX) || (reg_n_in > N_MAX);

  assign busy  = state_q != IDLE;
  assign ack   = (state_q == DONE) || (state_q == ERR);
  assign error = state_q == ERR;

  always_comb begin
    row_nx = row_q;
    col_nx = col_q + NBITS'(1);
    if (last_col) begin
      col_nx = '0;
      row_nx = row_q + MBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = FETCH;
      FETCH:   state_d = CHECK;
      CHECK:   state_d = bad_dims ? ERR : STREAM;
      STREAM:  if (hs && last) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // element/element_valid are registered; the first STREAM cycle loads the
  // head element, after which each handshake preloads the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_store_addr <= '0;
      snap_q         <= '0;
      matrix_m_size  <= '0;
      matrix_n_size  <= '0;
      row_q          <= '0;
      col_q          <= '0;
      element        <= '0;
      element_valid  <= 1'b0;
`ifdef MPU_STORE_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (en) reg_store_addr <= store_addr;
        CHECK: begin
          snap_q        <= reg_matrix_in;
          matrix_m_size <= reg_m_in;
          matrix_n_size <= reg_n_in;
          row_q         <= '0;
          col_q         <= '0;
`ifdef MPU_STORE_CHECKSUM_EN
          checksum      <= '0;
`endif
        end
        STREAM: begin
          if (!element_valid) begin
            element       <= snap_q[row_q][col_q];
            element_valid <= 1'b1;
          end else if (hs) begin
`ifdef MPU_STORE_CHECKSUM_EN
            checksum <= checksum ^ element;
`endif
            if (last) begin
              element_valid <= 1'b0;
            end else begin
              row_q   <= row_nx;
              col_q   <= col_nx;
              element <= snap_q[row_nx][col_nx];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
